cache_arbiter: RTL and testbench

- Shares the single line-wide physical memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache controllers, each of which sits behind its own word-to-line bus adapter, and the cacheline adapter / main memory.
- Grants one line transaction at a time using round-robin priority.
- Latches the granted request and routes the memory response back only to the granted requester.

---
 rtl/cache_arbiter_if.sv | 33 +++
 rtl/cache_arbiter.sv | 109 ++++++++++
 tb/tb_cache_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - icache/dcache/memory line bus bundle for cache_arbiter
interface cache_arbiter_if #(
  parameter int s_line = 256
);
  logic              i_read;
  logic [31:0]       i_addr;
  logic [s_line-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [31:0]       d_addr;
  logic [s_line-1:0] d_wdata;
  logic [s_line-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [s_line-1:0] mem_wdata;
  logic [s_line-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one line memory port between icache and dcache
module cache_arbiter #(
  parameter int s_line  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  cache_arbiter_if.master  bus,
  output logic             timeout_err
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  state_t            state, state_nxt;
  logic              i_req, d_req, grant_i, grant_d;
  logic              last_d;
  logic [31:0]       wd_cnt;
  logic [31:0]       wd_inc;
  logic [s_line-1:0] i_rdata_q, d_rdata_q;

  assign i_req   = bus.i_read;
  assign d_req   = bus.d_read | bus.d_write;
  // On contention the side that did not win last time goes first.
  assign grant_i = i_req & (~d_req | last_d);
  assign grant_d = d_req & ~grant_i;
  assign wd_inc  = (wd_cnt == 32'hFFFF_FFFF) ? wd_cnt : wd_cnt + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I, SERVE_D: if (bus.mem_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response data is forwarded in the mem_resp cycle and also kept for later reads.
  always_comb begin
    bus.i_resp  = 1'b0;
    bus.d_resp  = 1'b0;
    bus.i_rdata = i_rdata_q;
    bus.d_rdata = d_rdata_q;
    if (state == SERVE_I && bus.mem_resp) begin
      bus.i_resp  = 1'b1;
      bus.i_rdata = bus.mem_rdata;
    end
    if (state == SERVE_D && bus.mem_resp) begin
      bus.d_resp  = 1'b1;
      bus.d_rdata = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      last_d        <= 1'b1;
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            bus.mem_read  <= 1'b1;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= bus.i_addr;
            bus.mem_wdata <= '0;
            last_d        <= 1'b0;
            wd_cnt        <= '0;
          end else if (grant_d) begin
            // A simultaneous read+write from the dcache is a writeback.
            bus.mem_read  <= ~bus.d_write;
            bus.mem_write <= bus.d_write;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            last_d        <= 1'b1;
            wd_cnt        <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_resp) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (state == SERVE_I) i_rdata_q <= bus.mem_rdata;
            else                  d_rdata_q <= bus.mem_rdata;
          end else begin
            wd_cnt <= wd_inc;
            if (TIMEOUT_W != 32'd0 && wd_inc == TIMEOUT_W) timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
module tb_cache_arbiter;
  localparam int SL = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic timeout_err;

  cache_arbiter_if #(.s_line(SL)) bus ();

  cache_arbiter #(.s_line(SL), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic [31:0]   addr;
    logic          wr;
    logic [SL-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input logic is_d, input logic [31:0] a, input logic wr,
                            input logic [SL-1:0] d);
    exp_t e;
    e.is_d  = is_d;
    e.addr  = a;
    e.wr    = wr;
    e.rdata = d;
    sb.push_back(e);
  endtask

  task automatic wait_strobe();
    int k;
    k = 0;
    while (!(bus.mem_read || bus.mem_write) && k < 20) begin
      tick();
      k++;
    end
    chk("strobe_wait", SL'(bus.mem_read || bus.mem_write), SL'(1));
  endtask

  task automatic respond(input logic [SL-1:0] data, input int lat);
    repeat (lat) tick();
    bus.mem_rdata = data;
    bus.mem_resp  = 1'b1;
    tick();
    bus.mem_resp  = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest expected transaction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.i_resp || bus.d_resp) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", SL'({bus.i_resp, bus.d_resp}), SL'(0));
      end else begin
        e = sb.pop_front();
        chk("resp_who", SL'({bus.i_resp, bus.d_resp}), e.is_d ? SL'(2'b01) : SL'(2'b10));
        chk("resp_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
        chk("resp_addr", SL'(bus.mem_addr), SL'(e.addr));
        chk("resp_op", SL'({bus.mem_read, bus.mem_write}), e.wr ? SL'(2'b01) : SL'(2'b10));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    logic [SL-1:0] dk;
    bus.i_read    = 1'b0;
    bus.i_addr    = '0;
    bus.d_read    = 1'b0;
    bus.d_write   = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
    rst = 1'b0;
    repeat (3) tick();

    chk("rst_mem_read", SL'(bus.mem_read), SL'(0));
    chk("rst_mem_write", SL'(bus.mem_write), SL'(0));
    chk("rst_mem_addr", SL'(bus.mem_addr), SL'(0));
    chk("rst_mem_wdata", bus.mem_wdata, SL'(0));
    chk("rst_resp", SL'({bus.i_resp, bus.d_resp}), SL'(0));
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, SL'(0));
    chk("rst_timeout_err", SL'(timeout_err), SL'(0));
    rst = 1'b1;
    tick();

    // Single icache read, strobe one cycle after the request.
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_1040;
    expect_txn(1'b0, 32'h0000_1040, 1'b0, {32{8'hAA}});
    tick();
    chk("t1_mem_read", SL'(bus.mem_read), SL'(1));
    chk("t1_mem_addr", SL'(bus.mem_addr), SL'(32'h0000_1040));
    respond({32{8'hAA}}, 0);
    bus.i_read = 1'b0;
    chk("t1_read_cleared", SL'(bus.mem_read), SL'(0));
    chk("t1_rdata_held", bus.i_rdata, {32{8'hAA}});
    tick();

    // Dcache writeback.
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_2000;
    bus.d_wdata = {32{8'h55}};
    expect_txn(1'b1, 32'h0000_2000, 1'b1, SL'(0));
    tick();
    chk("t2_mem_write", SL'({bus.mem_read, bus.mem_write}), SL'(2'b01));
    chk("t2_mem_addr", SL'(bus.mem_addr), SL'(32'h0000_2000));
    chk("t2_mem_wdata", bus.mem_wdata, {32{8'h55}});
    respond(SL'(0), 2);
    bus.d_write = 1'b0;
    chk("t2_d_resp_one_cycle", SL'(bus.d_resp), SL'(0));
    tick();

    // Contention out of reset: I wins first, then D.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_5000;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_6000;
    expect_txn(1'b0, 32'h0000_5000, 1'b0, {8{32'h1111_2222}});
    expect_txn(1'b1, 32'h0000_6000, 1'b0, {8{32'h3333_4444}});
    tick();
    chk("t3_first_i", SL'(bus.mem_addr), SL'(32'h0000_5000));
    respond({8{32'h1111_2222}}, 1);
    bus.i_read = 1'b0;
    wait_strobe();
    chk("t3_then_d", SL'(bus.mem_addr), SL'(32'h0000_6000));
    respond({8{32'h3333_4444}}, 0);
    bus.d_read = 1'b0;
    tick();

    // Both held for six transactions: strict alternation starting with I.
    bus.i_addr = 32'h0000_7000;
    bus.d_addr = 32'h0000_8000;
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      dk = {8{32'(k + 1) ^ 32'hA5A5_0000}};
      expect_txn(k[0], k[0] ? 32'h0000_8000 : 32'h0000_7000, 1'b0, dk);
    end
    for (int k = 0; k < 6; k++) begin
      dk = {8{32'(k + 1) ^ 32'hA5A5_0000}};
      wait_strobe();
      chk("t4_alt_addr", SL'(bus.mem_addr), k[0] ? SL'(32'h0000_8000) : SL'(32'h0000_7000));
      respond(dk, k % 3);
      chk("t4_gap", SL'({bus.mem_read, bus.mem_write}), SL'(0));
    end
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    tick();
    tick();
    chk("t4_no_extra_grant", SL'({bus.mem_read, bus.mem_write}), SL'(0));

    // Requester address change during service is ignored.
    bus.d_read = 1'b1;
    bus.d_addr = 32'h0000_0100;
    expect_txn(1'b1, 32'h0000_0100, 1'b0, {8{32'hDEAD_BEEF}});
    tick();
    chk("t5_addr", SL'(bus.mem_addr), SL'(32'h0000_0100));
    bus.d_addr = 32'h0000_0200;
    repeat (3) begin
      tick();
      chk("t5_addr_held", SL'(bus.mem_addr), SL'(32'h0000_0100));
    end
    respond({8{32'hDEAD_BEEF}}, 0);
    bus.d_read = 1'b0;
    tick();

    // Watchdog sets after 8 waiting cycles and stays set.
    chk("t6_err_before", SL'(timeout_err), SL'(0));
    bus.i_read = 1'b1;
    bus.i_addr = 32'h0000_9000;
    expect_txn(1'b0, 32'h0000_9000, 1'b0, {8{32'h0BAD_F00D}});
    tick();
    repeat (7) tick();
    chk("t6_err_at_7", SL'(timeout_err), SL'(0));
    tick();
    chk("t6_err_at_8", SL'(timeout_err), SL'(1));
    respond({8{32'h0BAD_F00D}}, 2);
    bus.i_read = 1'b0;
    chk("t6_err_after_resp", SL'(timeout_err), SL'(1));
    tick();
    chk("t6_err_sticky", SL'(timeout_err), SL'(1));

    // Reset mid-transaction aborts without a response.
    bus.d_write = 1'b1;
    bus.d_addr  = 32'h0000_4000;
    bus.d_wdata = {8{32'hCAFE_0001}};
    tick();
    chk("t7_mem_write", SL'(bus.mem_write), SL'(1));
    tick();
    rst = 1'b0;
    #1;
    chk("t7_rst_strobes", SL'({bus.mem_read, bus.mem_write}), SL'(0));
    chk("t7_rst_addr", SL'(bus.mem_addr), SL'(0));
    chk("t7_rst_wdata", bus.mem_wdata, SL'(0));
    chk("t7_rst_rdata", bus.i_rdata | bus.d_rdata, SL'(0));
    chk("t7_rst_err", SL'(timeout_err), SL'(0));
    chk("t7_rst_resp", SL'({bus.i_resp, bus.d_resp}), SL'(0));
    bus.d_write = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("t7_idle_after_rst", SL'({bus.mem_read, bus.mem_write}), SL'(0));

    // Stray mem_resp while idle is not routed.
    bus.mem_resp = 1'b1;
    #1;
    chk("t8_idle_resp", SL'({bus.i_resp, bus.d_resp}), SL'(0));
    tick();
    bus.mem_resp = 1'b0;
    tick();
    tick();
    chk("sb_empty", SL'(sb.size()), SL'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
